// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares one single-port, byte-lane data RAM between two
// masters. m0 is the CPU MEM-stage port and m1 is a secondary master.
// Each access takes three states: IDLE (arbitrate and latch), ACCESS
// (the RAM samples its inputs) and RESP (registered read data is returned).
//
// Optional feature, selected by the macro DATA_RAM_ARB_RR_EN:
//   - defined  : round-robin arbitration using rr_last.
//   - undefined: fixed priority to m0, with a starvation limit for m1.
module data_ram_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [ADDR_W/8-1:0]   m0_sel,
  input  logic [ADDR_W-1:0]     m0_wdata,
  output logic [ADDR_W-1:0]     m0_rdata,
  output logic                  m0_ack,
  output logic                  m0_stall,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [ADDR_W/8-1:0]   m1_sel,
  input  logic [ADDR_W-1:0]     m1_wdata,
  output logic [ADDR_W-1:0]     m1_rdata,
  output logic                  m1_ack,

  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [ADDR_W/8-1:0]   ram_sel,
  output logic [ADDR_W-1:0]     ram_wdata,
  input  logic [ADDR_W-1:0]     ram_rdata
);

  localparam int SEL_W = ADDR_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ram_ce_q, ram_ce_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [SEL_W-1:0]    ram_sel_q, ram_sel_d;
  logic [ADDR_W-1:0]   ram_wdata_q, ram_wdata_d;
  // Winner id (0 = m0, 1 = m1) and its direction. These are kept through
  // RESP so that the ack and the read data reach the right master.
  logic                win_id_q, win_id_d;
  logic                win_we_q, win_we_d;

  logic                any_req;
  logic                grant_m1;
  logic                arb_decide;
  logic [ADDR_W-1:0]   resp_data;

  assign any_req    = m0_req | m1_req;
  // An arbitration decision is made only in IDLE when a request is present.
  assign arb_decide = (state_q == S_IDLE) && any_req;

`ifdef DATA_RAM_ARB_RR_EN
  // Round-robin: on contention, the master that was not granted last wins.
  // rr_last starts at 1, so the first contended grant goes to m0.
  logic rr_last_q, rr_last_d;

  assign grant_m1 = m1_req & (~m0_req | ~rr_last_q);

  // Record the id of the most recent grant.
  always_comb begin
    rr_last_d = rr_last_q;
    if (arb_decide) begin
      rr_last_d = grant_m1;
    end
  end

  // Round-robin history register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`else
  // Fixed priority: m0 wins unless m1 has already lost STARVE_LIMIT times
  // in a row. In that case m1 is forced through once.
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign grant_m1 = m1_req & (~m0_req | (starve_cnt_q == STARVE_MAX));

  // Count m1 losses (saturating) and clear the count when m1 is granted.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_decide) begin
      if (grant_m1) begin
        starve_cnt_d = 4'd0;
      end else if (m1_req && (starve_cnt_q != 4'hF)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Next-state and next-RAM-command logic for the three-state transaction.
  always_comb begin
    state_d     = state_q;
    ram_ce_d    = ram_ce_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_sel_d   = ram_sel_q;
    ram_wdata_d = ram_wdata_q;
    win_id_d    = win_id_q;
    win_we_d    = win_we_q;

    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Latch the winner's command. It is presented to the RAM
          // during ACCESS.
          win_id_d    = grant_m1;
          win_we_d    = grant_m1 ? m1_we    : m0_we;
          ram_ce_d    = 1'b1;
          ram_we_d    = grant_m1 ? m1_we    : m0_we;
          ram_addr_d  = grant_m1 ? m1_addr  : m0_addr;
          ram_sel_d   = grant_m1 ? m1_sel   : m0_sel;
          ram_wdata_d = grant_m1 ? m1_wdata : m0_wdata;
          state_d     = S_ACCESS;
        end else begin
          ram_ce_d    = 1'b0;
          ram_we_d    = 1'b0;
          ram_addr_d  = '0;
          ram_sel_d   = '0;
          ram_wdata_d = '0;
        end
      end

      S_ACCESS: begin
        // The RAM captures the command at the end of this cycle. Drop the
        // strobes so that the access happens exactly once.
        ram_ce_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = S_RESP;
      end

      S_RESP: begin
        // The read data is on ram_rdata now. Clear the remaining command
        // fields so that the RAM bus is idle while back in IDLE.
        ram_addr_d  = '0;
        ram_sel_d   = '0;
        ram_wdata_d = '0;
        state_d     = S_IDLE;
      end

      default: begin
        ram_ce_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = '0;
        ram_sel_d   = '0;
        ram_wdata_d = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and RAM command registers. The reset drops ram_ce immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_sel_q   <= '0;
      ram_wdata_q <= '0;
      win_id_q    <= 1'b0;
      win_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_sel_q   <= ram_sel_d;
      ram_wdata_q <= ram_wdata_d;
      win_id_q    <= win_id_d;
      win_we_q    <= win_we_d;
    end
  end

  // Response decode. The ack is high for the single RESP cycle. A write
  // returns zero, and each rdata is forced to zero whenever its ack is low.
  assign resp_data = win_we_q ? '0 : ram_rdata;
  assign m0_ack    = (state_q == S_RESP) & ~win_id_q;
  assign m1_ack    = (state_q == S_RESP) &  win_id_q;
  assign m0_rdata  = m0_ack ? resp_data : '0;
  assign m1_rdata  = m1_ack ? resp_data : '0;
  assign m0_stall  = m0_req & ~m0_ack;

  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_sel   = ram_sel_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port, byte-lane data RAM between two requesters: m0 (CPU MEM-stage load/store port) and m1 (secondary master, e.g. program loader or debug/DMA port).
- Sequences each access as a three-state transaction, accounting for the RAM's one-cycle synchronous read.
- Returns read data and a one-cycle ack to the winning requester.
- Raises a stall towards the pipeline while m0 waits.

Parameters:
- ADDR_W, 32, address / data width (matches RegBus).
- STARVE_LIMIT, 4, consecutive m1 losses tolerated before m1 is forced a grant (fixed-priority mode); legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 access request; held until m0_ack.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  32  byte address.
- m0_sel  in  4  byte-lane enables, bit0 = data[7:0].
- m0_wdata  in  32  write data.
- m0_rdata  out  32  read data; valid while m0_ack = 1.
- m0_ack  out  1  one-cycle completion pulse.
- m0_stall  out  1  = m0_req & ~m0_ack; pipeline stall request.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack: same as the m0 equivalents, for m1.
- ram_ce  out  1  RAM chip enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_sel  out  4  RAM byte lanes.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM registered read data; valid the cycle after ce.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - ram_ce/ram_we = 0; ram_addr/sel/wdata = 0.
  - both acks = 0; both rdata = 0.
  - starve_cnt = 0; rr_last = 1.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Transaction latency is 3 cycles from req sampled in IDLE to ack. Maximum throughput is one access per 3 cycles.
- IDLE:
  - If any req is high, arbitrate and latch the winner's id, we, addr, sel and wdata into the ram_* registers.
  - Assert ram_ce = 1 and ram_we = the winner's we, both registered. Go to ACCESS.
  - If no req is high, hold all ram_* outputs at 0.
- ACCESS:
  - ram_* outputs are stable for exactly one cycle; the RAM samples them at the end of this cycle.
  - Next state is RESP, with ram_ce and ram_we cleared on entry to RESP.
- RESP:
  - Assert the winner's ack for exactly one cycle.
  - Winner's rdata = ram_rdata for a read, 32'h0 for a write.
  - The loser's ack stays 0 and its rdata stays 0. Go to IDLE.
- rdata is 0 whenever the corresponding ack is 0.
- Arbitration (fixed priority, default):
  - m0 wins whenever m0_req = 1, unless starve_cnt == STARVE_LIMIT and m1_req = 1; in that case m1 wins.
  - starve_cnt increments (saturating) on each IDLE decision where m1_req = 1 and m0 wins.
  - starve_cnt clears when m1 is granted.
- Request drop: a req dropped after its grant does not abort the transaction. A write still completes and the ack still pulses; requesters ignore it.
- Request data: a req and its data must be held stable until ack. The arbiter latches request data only in IDLE.
- Simultaneous requests: exactly one grant per IDLE cycle; the loser keeps waiting with no ack.
- Reset mid-transaction:
  - Forces IDLE immediately and drops ram_ce.
  - A write in ACCESS whose RAM edge was not reached is lost; no ack is issued.
- ram_sel is passed through unmodified, including 4'b0000: ce is still asserted, no lanes are written, and the read returns the RAM's output.
- The address is passed through unmodified; RAM word indexing uses addr[..:2].

Optional Feature:
- Macro DATA_RAM_ARB_RR_EN.
- When defined: arbitration is round-robin. On contention the master not equal to rr_last wins; rr_last updates to the granted id on every grant. A lone requester always wins. starve_cnt and STARVE_LIMIT are unused and the starve_cnt logic is not generated.
- When undefined: fixed priority with the starvation limit described under Behaviour.

Test Plan:
- m0 read, addr 32'h10, sel 4'hF, RAM word 32'hDEADBEEF: m0_ack high in cycle 3 after req, m0_rdata = 32'hDEADBEEF; m0_stall high for cycles 1-2.
- m1 write, addr 32'h20, sel 4'b0011, wdata 32'h12345678: ram_ce = ram_we = 1 in ACCESS only; subsequent read of 32'h20 returns 32'h????5678 (lanes 3:2 unchanged); m1_rdata = 0 at ack.
- m0 and m1 both held high continuously, STARVE_LIMIT = 4, fixed priority: grant order m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
- Same stimulus with DATA_RAM_ARB_RR_EN defined: grants alternate m0,m1,m0,m1,... (first grant m0 after reset).
- rst asserted (low) in ACCESS of an m0 write: ram_ce drops asynchronously, no m0_ack ever pulses, state IDLE, all outputs 0.
- m0_req dropped in ACCESS of a read: m0_ack still pulses one cycle in RESP; the next IDLE with only m1_req grants m1.
